watch_display_driver: RTL and testbench



---
 rtl/watch_display_driver_pkg.sv | 42 ++++
 rtl/watch_display_driver_bcd_to_7seg.sv | 27 ++
 rtl/watch_display_driver.sv | 120 ++++++++++++
 tb/tb_watch_display_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/watch_display_driver_pkg.sv
// Shared constants for the watch display driver: segment patterns, digit
// positions and the mode encodings coming from the watch FSM.
package watch_display_pkg;

   // Active-low segment patterns, bit0 = a ... bit6 = g
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [2:0] S_UNI = 3'd0;
   localparam logic [2:0] S_DEZ = 3'd1;
   localparam logic [2:0] M_UNI = 3'd2;
   localparam logic [2:0] M_DEZ = 3'd3;
   localparam logic [2:0] H_UNI = 3'd4;
   localparam logic [2:0] H_DEZ = 3'd5;

   typedef enum logic [1:0] {
      RELOGIO    = 2'b00,
      CRONOMETRO = 2'b01,
      CFG        = 2'b10,
      MODE_NONE  = 2'b11
   } mode_t;

   function automatic logic [2:0] mode_to_led(input mode_t i_mode);
      case (i_mode)
         RELOGIO:    mode_to_led = 3'b001;
         CRONOMETRO: mode_to_led = 3'b010;
         CFG:        mode_to_led = 3'b100;
         default:    mode_to_led = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/watch_display_driver_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes
// show a dash so a corrupted digit is visible rather than misleading.
module bcd_to_7seg
   import watch_display_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg_n
);

   always_comb begin
      o_seg_n = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg_n = SEG_0;
         4'd1:    o_seg_n = SEG_1;
         4'd2:    o_seg_n = SEG_2;
         4'd3:    o_seg_n = SEG_3;
         4'd4:    o_seg_n = SEG_4;
         4'd5:    o_seg_n = SEG_5;
         4'd6:    o_seg_n = SEG_6;
         4'd7:    o_seg_n = SEG_7;
         4'd8:    o_seg_n = SEG_8;
         4'd9:    o_seg_n = SEG_9;
         default: o_seg_n = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/watch_display_driver.sv
// Multiplexes six BCD digits onto a shared seven-segment bus, blinks the
// digit under edit in configuration mode and drives the mode LEDs.
module watch_display_driver
   import watch_display_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 12500000,
   parameter int GUARD     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] s_unidade,
   input  logic [3:0] s_dezena,
   input  logic [3:0] m_unidade,
   input  logic [3:0] m_dezena,
   input  logic [3:0] h_unidade,
   input  logic [3:0] h_dezena,
   input  logic [2:0] config_digit,
   input  logic       is_config,
   input  logic [1:0] state_in,
   output logic [6:0] seg_n,
   output logic [5:0] an_n,
   output logic [2:0] mode_led
);

   localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCAN_W-1:0]  GUARD_C    = SCAN_W'(GUARD);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [SCAN_W-1:0]  r_scan_cnt;
   logic [2:0]         r_idx;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_blink_phase;
   logic               r_is_config_d;
   logic [2:0]         r_config_digit_d;
   logic [6:0]         r_seg_n;
   logic [5:0]         r_an_n;
   logic [2:0]         r_mode_led;

   logic [3:0] w_digit;
   logic [6:0] w_seg_n;
   logic [5:0] w_an_n;
   logic       w_restart;
   logic       w_phase_eff;
   logic       w_blank;

   always_comb begin
      w_digit = 4'hF;
      case (r_idx)
         S_UNI:   w_digit = s_unidade;
         S_DEZ:   w_digit = s_dezena;
         M_UNI:   w_digit = m_unidade;
         M_DEZ:   w_digit = m_dezena;
         H_UNI:   w_digit = h_unidade;
         H_DEZ:   w_digit = h_dezena;
         default: w_digit = 4'hF;
      endcase
   end

   bcd_to_7seg u_dec (
      .i_bcd   (w_digit),
      .o_seg_n (w_seg_n)
   );

   // A restart shows the edited digit in the same update that sees the change.
   always_comb begin
      w_restart   = is_config & (~r_is_config_d | (config_digit != r_config_digit_d));
      w_phase_eff = w_restart ? 1'b0 : r_blink_phase;
      w_blank     = is_config & (config_digit == r_idx) & w_phase_eff;
      if (r_scan_cnt < GUARD_C) begin
         w_an_n = 6'h3F;
      end else begin
         w_an_n = ~(6'b000001 << r_idx);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scan_cnt       <= '0;
         r_idx            <= S_UNI;
         r_blink_cnt      <= '0;
         r_blink_phase    <= 1'b0;
         r_is_config_d    <= 1'b0;
         r_config_digit_d <= 3'd0;
         r_seg_n          <= SEG_BLANK;
         r_an_n           <= 6'h3F;
         r_mode_led       <= 3'b000;
      end else begin
         if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == H_DEZ) ? S_UNI : r_idx + 3'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
         end

         if (w_restart) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
         end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
         end

         r_is_config_d    <= is_config;
         r_config_digit_d <= config_digit;
         r_seg_n          <= w_blank ? SEG_BLANK : w_seg_n;
         r_an_n           <= w_an_n;
         r_mode_led       <= mode_to_led(mode_t'(state_in));
      end
   end

   assign seg_n    = r_seg_n;
   assign an_n     = r_an_n;
   assign mode_led = r_mode_led;

endmodule

// File: tb/tb_watch_display_driver.sv
// Directed bench for watch_display_driver with short scan and blink periods.
module tb_watch_display_driver;

   localparam int SD = 4;
   localparam int G  = 1;
   localparam int BD = 16;

   logic       clk;
   logic       reset;
   logic [3:0] dig [6];
   logic [2:0] config_digit;
   logic       is_config;
   logic [1:0] state_in;
   logic [6:0] seg_n;
   logic [5:0] an_n;
   logic [2:0] mode_led;

   int tests = 0;
   int fails = 0;
   int k = 0;
   int blink_ref = 0;

   localparam logic [5:0] AN_TAB  [12] = '{6'h3F, 6'h3E, 6'h3E, 6'h3E, 6'h3F, 6'h3D,
                                           6'h3D, 6'h3D, 6'h3F, 6'h3B, 6'h3B, 6'h3B};
   localparam logic [6:0] SEG_TAB [12] = '{7'h02, 7'h02, 7'h02, 7'h02, 7'h12, 7'h12,
                                           7'h12, 7'h12, 7'h19, 7'h19, 7'h19, 7'h19};
   localparam logic [2:0] LED_TAB [4]  = '{3'b010, 3'b100, 3'b000, 3'b001};
   localparam logic [1:0] ST_TAB  [4]  = '{2'b01, 2'b10, 2'b11, 2'b00};

   watch_display_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD), .GUARD(G)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_unidade    (dig[0]),
      .s_dezena     (dig[1]),
      .m_unidade    (dig[2]),
      .m_dezena     (dig[3]),
      .h_unidade    (dig[4]),
      .h_dezena     (dig[5]),
      .config_digit (config_digit),
      .is_config    (is_config),
      .state_in     (state_in),
      .seg_n        (seg_n),
      .an_n         (an_n),
      .mode_led     (mode_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] pat(input logic [3:0] v);
      case (v)
         4'd0:    pat = 7'h40;
         4'd1:    pat = 7'h79;
         4'd2:    pat = 7'h24;
         4'd3:    pat = 7'h30;
         4'd4:    pat = 7'h19;
         4'd5:    pat = 7'h12;
         4'd6:    pat = 7'h02;
         4'd7:    pat = 7'h78;
         4'd8:    pat = 7'h00;
         4'd9:    pat = 7'h10;
         default: pat = 7'h3F;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s (cycle %0d): observed %h expected %h", tag, k, obs, exp_v);
      end
   endtask

   // One clock; expected anode/segment derived from cycles since reset release.
   task automatic step(input string tag);
      int c, idx, j;
      logic [5:0] ea;
      logic [6:0] es;
      @(posedge clk); #1;
      k++;
      c   = (k - 1) % SD;
      idx = ((k - 1) / SD) % 6;
      ea  = (c < G) ? 6'h3F : ~(6'b000001 << idx);
      es  = pat(dig[idx]);
      j   = k - blink_ref;
      if (is_config && (int'(config_digit) == idx) && j >= 1 && (((j - 1) / BD) % 2) == 1)
         es = 7'h7F;
      chk({tag, "_an"}, {2'b00, an_n}, {2'b00, ea});
      chk({tag, "_seg"}, {1'b0, seg_n}, {1'b0, es});
   endtask

   initial begin
      reset = 1'b0;
      dig[0] = 4'd6; dig[1] = 4'd5; dig[2] = 4'd4;
      dig[3] = 4'd3; dig[4] = 4'd2; dig[5] = 4'd1;
      config_digit = 3'd0;
      is_config = 1'b0;
      state_in = 2'b00;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_seg", {1'b0, seg_n}, 8'h7F);
      chk("rst_an", {2'b00, an_n}, 8'h3F);
      chk("rst_led", {5'd0, mode_led}, 8'h00);

      @(negedge clk);
      reset = 1'b1;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         k++;
         chk("post_rst_an", {2'b00, an_n}, {2'b00, AN_TAB[i]});
         chk("post_rst_seg", {1'b0, seg_n}, {1'b0, SEG_TAB[i]});
      end
      chk("led_clock", {5'd0, mode_led}, 8'h01);

      @(negedge clk);
      dig[0] = 4'hC;
      repeat (24) step("dash");

      @(negedge clk);
      dig[1] = 4'd0; dig[2] = 4'd7; dig[3] = 4'd9; dig[4] = 4'd8;
      repeat (24) step("pat");

      @(negedge clk);
      is_config = 1'b1;
      config_digit = 3'd2;
      blink_ref = k + 1;
      repeat (30) step("blink2");

      @(negedge clk);
      config_digit = 3'd3;
      blink_ref = k + 1;
      repeat (60) step("blink3");

      @(negedge clk);
      config_digit = 3'd6;
      blink_ref = k + 1;
      repeat (40) step("cfg6");

      @(negedge clk);
      is_config = 1'b0;
      repeat (8) step("cfg_off");

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         state_in = ST_TAB[i];
         @(posedge clk); #1;
         k++;
         chk("mode_led", {5'd0, mode_led}, {5'd0, LED_TAB[i]});
      end

      for (int n = 0; n < 30 && an_n !== 6'h3B; n++) begin
         @(posedge clk); #1;
         k++;
      end
      chk("wait_idx2", {2'b00, an_n}, 8'h3B);
      #1;
      reset = 1'b0;
      #1;
      chk("async_rst_seg", {1'b0, seg_n}, 8'h7F);
      chk("async_rst_an", {2'b00, an_n}, 8'h3F);
      chk("async_rst_led", {5'd0, mode_led}, 8'h00);

      @(negedge clk);
      reset = 1'b1;
      k = 0;
      repeat (10) step("restart");
      chk("restart_led", {5'd0, mode_led}, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
